alu_reg_issue: RTL

Register-file and issue stage sitting directly upstream of the 8-bit combinational ALU. It accepts 3-operand register instructions over a valid/ready handshake and reads operands from an 8-entry × 8-bit register file. It drives the ALU's `a`, `b` and 3-bit opcode inputs from a registered execute stage, then captures the ALU result and writes it back to the register file. Sustained throughput is one instruction per cycle when no hazard stall applies.

---
 rtl/alu_reg_issue.sv | 92 +++++++++
 1 files changed

// File: rtl/alu_reg_issue.sv
// alu_reg_issue: register file and issue stage feeding a combinational 8-bit ALU
// Ports: clk; reset_n (synchronous, active-low); instr_valid_i/instr_ready_o handshake for
// instr_op_i/instr_rd_i/instr_rs1_i/instr_rs2_i; alu_a_o/alu_b_o/alu_op_o driven from EX
// registers with alu_res_i returned; wb_valid_o/wb_rd_o/wb_data_o write-back pulse;
// dbg_addr_i/dbg_data_o combinational RF read (r0 reads 0).
// Define ALU_REG_ISSUE_FWD_EN to forward alu_res_i into operands instead of stalling.
module alu_reg_issue (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       instr_valid_i,
  output logic       instr_ready_o,
  input  logic [2:0] instr_op_i,
  input  logic [2:0] instr_rd_i,
  input  logic [2:0] instr_rs1_i,
  input  logic [2:0] instr_rs2_i,
  output logic [7:0] alu_a_o,
  output logic [7:0] alu_b_o,
  output logic [2:0] alu_op_o,
  input  logic [7:0] alu_res_i,
  output logic       wb_valid_o,
  output logic [2:0] wb_rd_o,
  output logic [7:0] wb_data_o,
  input  logic [2:0] dbg_addr_i,
  output logic [7:0] dbg_data_o
);
  logic [7:0] rf_q [8];
  logic [7:0] rf_d [8];
  logic       ex_v_q, ex_v_d, wb_v_q, wb_v_d;
  logic [7:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d, wb_data_q, wb_data_d;
  logic [2:0] ex_op_q, ex_op_d, ex_rd_q, ex_rd_d, wb_rd_q, wb_rd_d;
  logic       fwd_a, fwd_b, stall, acc;
  logic [7:0] op_a, op_b;
`ifdef ALU_REG_ISSUE_FWD_EN
  assign fwd_a = ex_v_q && ex_rd_q == instr_rs1_i;
  assign fwd_b = ex_v_q && ex_rd_q == instr_rs2_i;
  assign stall = 1'b0;
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
  // the EX result is not yet visible anywhere readable; wait one cycle for the WB bypass
  assign stall = ex_v_q && ex_rd_q != 3'd0 &&
                 (ex_rd_q == instr_rs1_i || ex_rd_q == instr_rs2_i);
`endif
  assign instr_ready_o = reset_n && !stall;
  assign acc = instr_valid_i && instr_ready_o;
  assign op_a = instr_rs1_i == 3'd0 ? 8'h00 : fwd_a ? alu_res_i :
                (wb_v_q && wb_rd_q == instr_rs1_i) ? wb_data_q : rf_q[instr_rs1_i];
  assign op_b = instr_rs2_i == 3'd0 ? 8'h00 : fwd_b ? alu_res_i :
                (wb_v_q && wb_rd_q == instr_rs2_i) ? wb_data_q : rf_q[instr_rs2_i];
  assign alu_a_o = ex_a_q;
  assign alu_b_o = ex_b_q;
  assign alu_op_o = ex_op_q;
  assign wb_valid_o = wb_v_q;
  assign wb_rd_o = wb_rd_q;
  assign wb_data_o = wb_data_q;
  assign dbg_data_o = dbg_addr_i == 3'd0 ? 8'h00 : rf_q[dbg_addr_i];
  always_comb begin
    rf_d = rf_q;
    if (wb_v_q && wb_rd_q != 3'd0) rf_d[wb_rd_q] = wb_data_q;
    ex_v_d = acc;
    ex_a_d = acc ? op_a : ex_a_q;
    ex_b_d = acc ? op_b : ex_b_q;
    ex_op_d = acc ? instr_op_i : ex_op_q;
    ex_rd_d = acc ? instr_rd_i : ex_rd_q;
    wb_v_d = ex_v_q;
    wb_rd_d = ex_v_q ? ex_rd_q : wb_rd_q;
    wb_data_d = ex_v_q ? alu_res_i : wb_data_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rf_q <= '{default: 8'h00};
      ex_v_q <= 1'b0;
      ex_a_q <= 8'h00;
      ex_b_q <= 8'h00;
      ex_op_q <= 3'd0;
      ex_rd_q <= 3'd0;
      wb_v_q <= 1'b0;
      wb_rd_q <= 3'd0;
      wb_data_q <= 8'h00;
    end else begin
      rf_q <= rf_d;
      ex_v_q <= ex_v_d;
      ex_a_q <= ex_a_d;
      ex_b_q <= ex_b_d;
      ex_op_q <= ex_op_d;
      ex_rd_q <= ex_rd_d;
      wb_v_q <= wb_v_d;
      wb_rd_q <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end
endmodule
